cr_kme_mc_fifo: RTL and testbench

//  Multi-channel successor to the single-channel KME staging FIFO.
//  NUM_CH independent FIFOs share one tagged write port and one round-robin arbitrated read port.

---
 rtl/cr_kme_mc_fifo_pkg.sv | 40 ++++
 rtl/cr_kme_mc_fifo_if.sv | 34 +++
 rtl/cr_kme_mc_fifo_ch.sv | 80 ++++++++
 rtl/cr_kme_mc_fifo.sv | 128 ++++++++++++
 tb/tb_cr_kme_mc_fifo.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_kme_mc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// cr_kme_mc_fifo_pkg
//   Shared types and helpers for the multi-channel KME staging FIFO.
//   - ch_stat_t : per-channel status {used, free, empty, full}. The count
//                 fields are ST_W wide so one type serves any FIFO_DEPTH up to
//                 2**ST_W-1. Users slice them down to their own count width.
//   - rr_next   : round-robin pick. Returns the first set bit of req at or
//                 after ptr, wrapping at n. It returns ptr when req is empty,
//                 so callers must qualify the result with |req.
// ---------------------------------------------------------------------------
package cr_kme_mc_fifo_pkg;

    localparam int ST_W = 8;

    typedef struct packed {
        logic [ST_W-1:0] used;
        logic [ST_W-1:0] free;
        logic            empty;
        logic            full;
    } ch_stat_t;

    // Supports up to 32 channels; ptr must be < n.
    function automatic int unsigned rr_next(input logic [31:0]  req,
                                            input int unsigned  ptr,
                                            input int unsigned  n);
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        rr_next = ptr;
        for (int unsigned i = 0; i < 32; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && (i < n) && req[idx[4:0]]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/cr_kme_mc_fifo_if.sv
// ---------------------------------------------------------------------------
// cr_kme_mc_fifo_if
//   Write-port and read-port handshake of the multi-channel KME FIFO.
//   master : producer/consumer side. It drives the write payload and the pop ack.
//   slave  : FIFO side. It drives the stall vector and the granted head.
//   Signals: fifo_in/fifo_in_ch/fifo_in_valid (tagged write),
//            fifo_in_stall (per-channel backpressure),
//            fifo_out/fifo_out_ch/fifo_out_valid/fifo_out_ack (arbitrated read).
// ---------------------------------------------------------------------------
interface cr_kme_mc_fifo_if #(
    parameter int DATA_SIZE = 10,
    parameter int NUM_CH    = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [DATA_SIZE-1:0] fifo_in;
    logic [CH_W-1:0]      fifo_in_ch;
    logic                 fifo_in_valid;
    logic [NUM_CH-1:0]    fifo_in_stall;
    logic [DATA_SIZE-1:0] fifo_out;
    logic [CH_W-1:0]      fifo_out_ch;
    logic                 fifo_out_valid;
    logic                 fifo_out_ack;

    modport master (
        output fifo_in, fifo_in_ch, fifo_in_valid, fifo_out_ack,
        input  fifo_in_stall, fifo_out, fifo_out_ch, fifo_out_valid
    );

    modport slave (
        input  fifo_in, fifo_in_ch, fifo_in_valid, fifo_out_ack,
        output fifo_in_stall, fifo_out, fifo_out_ch, fifo_out_valid
    );
endinterface

// File: rtl/cr_kme_mc_fifo_ch.sv
// ---------------------------------------------------------------------------
// cr_kme_mc_fifo_ch
//   One channel of the multi-channel KME FIFO. It holds the storage, the
//   read/write pointers and the occupancy count.
//   Ports: clk, rst (async, active-high); push/din write; pop removes head;
//          head = oldest entry; st = {used, free, empty, full};
//          ne_nxt = channel non-empty after this cycle (arbiter lookahead);
//          drop = this cycle's push was discarded (full, no same-cycle pop).
// ---------------------------------------------------------------------------
module cr_kme_mc_fifo_ch
    import cr_kme_mc_fifo_pkg::*;
#(
    parameter int DATA_SIZE  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] head,
    output ch_stat_t             st,
    output logic                 ne_nxt,
    output logic                 drop
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_DEPTH-1:0][DATA_SIZE-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic full, empty, do_push, do_pop;

    assign full    = (used_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (used_q == '0);
    assign do_pop  = pop & ~empty;
    // A same-cycle pop frees the slot, so a write to a full channel still lands.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        used_d = used_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop)
            rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            used_q <= used_d;
        end
    end

    assign head     = mem_q[rd_q];
    assign ne_nxt   = (used_d != '0);
    assign st.used  = ST_W'(used_q);
    assign st.free  = ST_W'(CNT_W'(FIFO_DEPTH) - used_q);
    assign st.empty = empty;
    assign st.full  = full;

endmodule

// File: rtl/cr_kme_mc_fifo.sv
// ---------------------------------------------------------------------------
// cr_kme_mc_fifo
//   Multi-channel KME staging FIFO. NUM_CH independent channel FIFOs share
//   one tagged write port and one round-robin arbitrated read port.
//   Ports: clk, rst (async, active-high);
//          bus (cr_kme_mc_fifo_if.slave): write/read handshake + stall vector;
//          fifo_in_stall_ovr / stall_at : per-channel forced stall / threshold;
//          fifo_overflow / fifo_underflow : sticky error flags; clr_errs clears;
//          wmark : per-channel high-watermark (only with CR_KME_MC_FIFO_WMARK_EN).
//   Optional feature macro: CR_KME_MC_FIFO_WMARK_EN.
// ---------------------------------------------------------------------------
module cr_kme_mc_fifo
    import cr_kme_mc_fifo_pkg::*;
#(
    parameter  int DATA_SIZE  = 10,
    parameter  int FIFO_DEPTH = 4,
    parameter  int NUM_CH     = 4,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    cr_kme_mc_fifo_if.slave              bus,
    input  logic [NUM_CH-1:0]            fifo_in_stall_ovr,
    input  logic [NUM_CH-1:0][CNT_W-1:0] stall_at,
    output logic [NUM_CH-1:0]            fifo_overflow,
    output logic                         fifo_underflow,
    input  logic                         clr_errs
`ifdef CR_KME_MC_FIFO_WMARK_EN
    ,
    output logic [NUM_CH-1:0][CNT_W-1:0] wmark
`endif
);
    logic [NUM_CH-1:0][DATA_SIZE-1:0] head;
    ch_stat_t [NUM_CH-1:0] st;
    logic [NUM_CH-1:0] push, pop, ne_nxt, drop, stall;
    logic              vld_q, vld_d, do_pop, hold;
    logic [CH_W-1:0]   gnt_q, gnt_d, rr_q, rr_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              unf_q, unf_d;

    assign do_pop = vld_q & bus.fifo_out_ack;
    assign hold   = vld_q & ~bus.fifo_out_ack;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c]  = bus.fifo_in_valid & (bus.fifo_in_ch == CH_W'(c));
        assign pop[c]   = do_pop & (gnt_q == CH_W'(c));
        // Comparing free slots against the threshold, so stall rises before full.
        assign stall[c] = (st[c].free[CNT_W-1:0] <= stall_at[c]) | fifo_in_stall_ovr[c];

        cr_kme_mc_fifo_ch #(
            .DATA_SIZE  (DATA_SIZE),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .push   (push[c]),
            .pop    (pop[c]),
            .din    (bus.fifo_in),
            .head   (head[c]),
            .st     (st[c]),
            .ne_nxt (ne_nxt[c]),
            .drop   (drop[c])
        );
    end

    always_comb begin
        vld_d = vld_q;
        gnt_d = gnt_q;
        rr_d  = rr_q;
        if (do_pop)
            rr_d = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
        // Arbitrate on next-cycle occupancy: a fresh write is grantable one
        // cycle later, and a popped channel loses priority to the others.
        if (!hold) begin
            vld_d = |ne_nxt;
            gnt_d = CH_W'(rr_next(32'(ne_nxt), 32'(rr_d), NUM_CH));
        end
        // A set event in the clear cycle takes priority.
        ovf_d = (ovf_q & ~{NUM_CH{clr_errs}}) | drop;
        unf_d = (unf_q & ~clr_errs) | (bus.fifo_out_ack & ~vld_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            gnt_q <= '0;
            rr_q  <= '0;
            ovf_q <= '0;
            unf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            gnt_q <= gnt_d;
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.fifo_in_stall  = stall;
    assign bus.fifo_out_valid = vld_q;
    assign bus.fifo_out_ch    = vld_q ? gnt_q : '0;
    assign bus.fifo_out       = vld_q ? head[gnt_q] : '0;
    assign fifo_overflow      = ovf_q;
    assign fifo_underflow     = unf_q;

`ifdef CR_KME_MC_FIFO_WMARK_EN
    logic [NUM_CH-1:0][CNT_W-1:0] wm_q, wm_d;

    always_comb begin
        wm_d = wm_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr_errs)
                wm_d[c] = '0;
            else if (st[c].used[CNT_W-1:0] > wm_q[c])
                wm_d[c] = st[c].used[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wm_q <= '0;
        else     wm_q <= wm_d;
    end

    assign wmark = wm_q;
`endif

endmodule

// File: tb/tb_cr_kme_mc_fifo.sv
// ---------------------------------------------------------------------------
// tb_cr_kme_mc_fifo
//   Self-checking bench for cr_kme_mc_fifo. A queue-per-channel reference
//   model tracks contents, grant, rr pointer and sticky flags. It runs the
//   directed scenarios first and then a randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_cr_kme_mc_fifo;
    localparam int DS    = 10;
    localparam int DEPTH = 4;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int CNTW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cr_kme_mc_fifo_if #(.DATA_SIZE(DS), .NUM_CH(NCH)) bus ();

    logic [NCH-1:0]           ovr;
    logic [NCH-1:0][CNTW-1:0] stall_at;
    logic [NCH-1:0]           ovf;
    logic                     unf;
    logic                     clr;
`ifdef CR_KME_MC_FIFO_WMARK_EN
    logic [NCH-1:0][CNTW-1:0] wmark;
`endif

    cr_kme_mc_fifo #(.DATA_SIZE(DS), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .fifo_in_stall_ovr (ovr),
        .stall_at          (stall_at),
        .fifo_overflow     (ovf),
        .fifo_underflow    (unf),
        .clr_errs          (clr)
`ifdef CR_KME_MC_FIFO_WMARK_EN
        ,
        .wmark             (wmark)
`endif
    );

    // Reference model state
    logic [DS-1:0]  mq [NCH][$];
    bit             m_vld;
    int             m_gch;
    int             m_rr;
    bit [NCH-1:0]   m_ovf;
    bit             m_unf;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_vld = 0; m_gch = 0; m_rr = 0; m_ovf = '0; m_unf = 0;
    endtask

    // Advance the model by one clock using the inputs that were sampled at the edge.
    task automatic model_step();
        bit           pop;
        int           wc;
        int           c;
        bit [NCH-1:0] set_ovf;
        pop     = m_vld && bus.fifo_out_ack;
        wc      = int'(bus.fifo_in_ch);
        set_ovf = '0;
        if (pop) void'(mq[m_gch].pop_front());
        if (bus.fifo_in_valid) begin
            if (mq[wc].size() < DEPTH) mq[wc].push_back(bus.fifo_in);
            else set_ovf[wc] = 1'b1;
        end
        m_ovf = (clr ? '0 : m_ovf) | set_ovf;
        m_unf = (clr ? 1'b0 : m_unf) | (bus.fifo_out_ack && !m_vld);
        if (pop) m_rr = (m_gch + 1) % NCH;
        if (!(m_vld && !bus.fifo_out_ack)) begin
            m_vld = 0;
            for (int i = 0; i < NCH; i++) begin
                c = (m_rr + i) % NCH;
                if (!m_vld && mq[c].size() > 0) begin
                    m_vld = 1; m_gch = c;
                end
            end
        end
    endtask

    task automatic check_stall();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++)
            e[c] = ((DEPTH - mq[c].size()) <= int'(stall_at[c])) || ovr[c];
        chk("stall", bus.fifo_in_stall, e);
    endtask

    task automatic compare();
        chk("valid", bus.fifo_out_valid, m_vld);
        if (m_vld) begin
            chk("out_ch", bus.fifo_out_ch, m_gch);
            chk("out_data", bus.fifo_out, mq[m_gch][0]);
        end
        chk("overflow", ovf, m_ovf);
        chk("underflow", unf, m_unf);
    endtask

    // One clock: drive inputs (called at negedge), step DUT and model, compare.
    task automatic cyc(input bit wv, input int wc, input logic [DS-1:0] wd,
                       input bit ack, input bit c);
        bus.fifo_in_valid = wv;
        bus.fifo_in_ch    = CHW'(wc);
        bus.fifo_in       = wd;
        bus.fifo_out_ack  = ack;
        clr               = c;
        #1 check_stall();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drain();
        int left;
        for (int i = 0; i < 64; i++) begin
            left = 0;
            for (int c = 0; c < NCH; c++) left += mq[c].size();
            if (left > 0) cyc(0, 0, '0, 1, 0);
        end
        left = 0;
        for (int c = 0; c < NCH; c++) left += mq[c].size();
        chk("drain_left", bus.fifo_out_valid, 1'b0);
        chk("drain_model", left, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.fifo_out_valid, 1'b0);
        chk({tag, "_out"}, bus.fifo_out, '0);
        chk({tag, "_ch"}, bus.fifo_out_ch, '0);
        chk({tag, "_ovf"}, ovf, '0);
        chk({tag, "_unf"}, unf, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DS-1:0] d0;
        int            seq [4];
        bus.fifo_in_valid = 0; bus.fifo_in_ch = '0; bus.fifo_in = '0; bus.fifo_out_ack = 0;
        clr = 0; ovr = '0; stall_at = '0;
        model_clear();
        rst = 1;
        #1 check_reset_outputs("rst0");
        check_stall();
        @(negedge clk); rst = 0;

        // 1: reset while ch1 holds three entries
        for (int i = 0; i < 3; i++) cyc(1, 1, DS'(10'h100 + i), 0, 0);
        chk("t1_pre_valid", bus.fifo_out_valid, 1'b1);
        #2 rst = 1;
        #1 model_clear();
        check_reset_outputs("t1_rst");
        check_stall();
        @(negedge clk); rst = 0;
        cyc(0, 0, '0, 0, 0);
        chk("t1_empty", bus.fifo_out_valid, 1'b0);

        // 2: threshold stall on ch0 only
        stall_at[0] = 3'd1;
        for (int i = 0; i < 3; i++) cyc(1, 0, DS'(10'h20 + i), 0, 0);
        #1 chk("t2_stall", bus.fifo_in_stall, 4'b0001);
        stall_at = '0;
        drain();

        // 3: ch0 and ch2 two entries each, ack held high
        cyc(1, 0, 10'h0a0, 0, 0);
        cyc(1, 2, 10'h2a0, 0, 0);
        cyc(1, 0, 10'h0a1, 0, 0);
        cyc(1, 2, 10'h2a1, 0, 0);
        seq = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            chk("t3_seq", bus.fifo_out_ch, seq[i]);
            cyc(0, 0, '0, 1, 0);
        end
        chk("t3_done", bus.fifo_out_valid, 1'b0);

        // 4: overflow on full ch3, then full write with same-cycle pop
        for (int i = 0; i < DEPTH; i++) cyc(1, 3, DS'(10'h300 + i), 0, 0);
        cyc(1, 3, 10'h3ff, 0, 0);
        chk("t4_ovf", ovf, 4'b1000);
        chk("t4_head", bus.fifo_out, 10'h300);
        cyc(0, 0, '0, 0, 1);
        chk("t4_clr", ovf, 4'b0000);
        cyc(1, 3, 10'h155, 1, 0);
        chk("t4_no_ovf", ovf, 4'b0000);
        drain();

        // 5: underflow, and set-wins-over-clear
        cyc(0, 0, '0, 1, 0);
        chk("t5_unf", unf, 1'b1);
        cyc(0, 0, '0, 1, 1);
        chk("t5_unf_hold", unf, 1'b1);
        cyc(0, 0, '0, 0, 1);
        chk("t5_unf_clr", unf, 1'b0);

        // 6: grant and data stable while ack low and writes arrive on ch1
        d0 = DS'($urandom);
        cyc(1, 0, d0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, DS'($urandom), 0, 0);
            chk("t6_ch", bus.fifo_out_ch, 0);
            chk("t6_data", bus.fifo_out, d0);
        end
        drain();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) begin
                for (int c = 0; c < NCH; c++) stall_at[c] = CNTW'($urandom_range(0, DEPTH));
                ovr = ($urandom % 4 == 0) ? NCH'($urandom) : '0;
            end
            cyc($urandom % 3 != 0, int'($urandom % NCH), DS'($urandom),
                $urandom % 3 != 0, $urandom % 32 == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
